// File: rtl/score_keeper.sv
// Jump-game scoring stage: turns landing/fall pulses into a saturating round score,
// a perfect-landing combo multiplier and a session high score, all registered.
module score_keeper #(
  parameter int MAX_SCORE   = 999,
  parameter int NORMAL_PTS  = 1,
  parameter int PERFECT_PTS = 2,
  parameter int COMBO_MAX   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_land,
  input  logic       i_perfect,
  input  logic       i_fall,
  output logic [9:0] o_score,
  output logic [9:0] o_high_score,
  output logic [2:0] o_combo,
  output logic       o_playing,
  output logic       o_score_pulse,
  output logic       o_new_record
);

  typedef enum logic [1:0] {S_IDLE, S_PLAYING, S_OVER} state_t;

  state_t      r_state, w_state_next;
  logic [9:0]  r_score, w_score_next;
  logic [9:0]  r_high, w_high_next;
  logic [2:0]  r_combo, w_combo_next, w_combo_inc;
  logic        r_new_rec, w_new_rec_next;
  logic        r_playing, r_score_pulse;
  logic [10:0] w_add, w_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_score       <= '0;
      r_high        <= '0;
      r_combo       <= '0;
      r_new_rec     <= 1'b0;
      r_playing     <= 1'b0;
      r_score_pulse <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_score       <= w_score_next;
      r_high        <= w_high_next;
      r_combo       <= w_combo_next;
      r_new_rec     <= w_new_rec_next;
      r_playing     <= (w_state_next == S_PLAYING);
      r_score_pulse <= (w_score_next != r_score);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_score_next   = r_score;
    w_high_next    = r_high;
    w_combo_next   = r_combo;
    w_new_rec_next = r_new_rec;
    w_add          = '0;
    w_sum          = '0;
    w_combo_inc    = (r_combo >= 3'(COMBO_MAX)) ? 3'(COMBO_MAX) : r_combo + 3'd1;
    case (r_state)
      S_IDLE, S_OVER: begin
        if (i_start) begin
          w_state_next   = S_PLAYING;
          w_score_next   = '0;
          w_combo_next   = '0;
          w_new_rec_next = 1'b0;
        end
      end
      S_PLAYING: begin
        // a fall in the same cycle as a landing ends the round; the landing is lost
        if (i_fall) begin
          w_state_next   = S_OVER;
          w_combo_next   = '0;
          w_new_rec_next = (r_score > r_high);
          if (r_score > r_high) w_high_next = r_score;
        end else if (i_land) begin
          if (i_perfect) begin
            w_combo_next = w_combo_inc;
            w_add        = 11'(PERFECT_PTS) * {8'd0, w_combo_inc};
          end else begin
            w_combo_next = '0;
            w_add        = 11'(NORMAL_PTS);
          end
          w_sum        = {1'b0, r_score} + w_add;
          w_score_next = (w_sum > 11'(MAX_SCORE)) ? 10'(MAX_SCORE) : w_sum[9:0];
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_score       = r_score;
  assign o_high_score  = r_high;
  assign o_combo       = r_combo;
  assign o_playing     = r_playing;
  assign o_score_pulse = r_score_pulse;
  assign o_new_record  = r_new_rec;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: integer game model checked every cycle, plus
// hand-computed literal checkpoints along the round sequence.
module tb_score_keeper;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0, i_land = 1'b0, i_perfect = 1'b0, i_fall = 1'b0;
  logic [9:0] o_score, o_high_score;
  logic [2:0] o_combo;
  logic       o_playing, o_score_pulse, o_new_record;

  int total = 0;
  int bad   = 0;

  score_keeper dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_land(i_land), .i_perfect(i_perfect),
    .i_fall(i_fall), .o_score(o_score), .o_high_score(o_high_score), .o_combo(o_combo),
    .o_playing(o_playing), .o_score_pulse(o_score_pulse), .o_new_record(o_new_record)
  );

  always #5 clk = ~clk;

  // model: plain integer game rules
  int m_round_on = 0, m_score = 0, m_high = 0, m_combo = 0, m_rec = 0, m_pulse = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    int prev, add;
    prev = m_score;
    if (rst) begin
      m_round_on = 0; m_score = 0; m_high = 0; m_combo = 0; m_rec = 0;
      m_valid = 1;
    end else if (m_round_on == 0) begin
      if (i_start) begin
        m_round_on = 1; m_score = 0; m_combo = 0; m_rec = 0;
      end
    end else if (i_fall) begin
      m_round_on = 0; m_combo = 0;
      m_rec = (m_score > m_high) ? 1 : 0;
      if (m_score > m_high) m_high = m_score;
    end else if (i_land) begin
      if (i_perfect) begin
        m_combo = (m_combo + 1 > 7) ? 7 : m_combo + 1;
        add = 2 * m_combo;
      end else begin
        m_combo = 0;
        add = 1;
      end
      m_score = (m_score + add > 999) ? 999 : m_score + add;
    end
    m_pulse = (!rst && m_score != prev) ? 1 : 0;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("score", int'(o_score), m_score);
      chk("high", int'(o_high_score), m_high);
      chk("combo", int'(o_combo), m_combo);
      chk("playing", int'(o_playing), m_round_on);
      chk("pulse", int'(o_score_pulse), m_pulse);
      chk("new_record", int'(o_new_record), m_rec);
    end
  end

  task automatic drive(input logic s, input logic l, input logic p, input logic f);
    i_start = s; i_land = l; i_perfect = p; i_fall = f;
    @(posedge clk);
    #1;
    i_start = 0; i_land = 0; i_perfect = 0; i_fall = 0;
  endtask

  initial begin
    int exp_pf[4];
    int exp_cb[4];
    exp_pf = '{2, 6, 12, 13};
    exp_cb = '{1, 2, 3, 0};

    for (int i = 0; i < 2; i++) begin
      i_start = 1'($urandom); i_land = 1'($urandom);
      i_perfect = 1'($urandom); i_fall = 1'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 0;
    i_start = 0; i_land = 0; i_perfect = 0; i_fall = 0;
    chk("rst_score", int'(o_score), 0);
    chk("rst_high", int'(o_high_score), 0);
    chk("rst_playing", int'(o_playing), 0);
    drive(0, 1, 1, 0);
    chk("idle_land_score", int'(o_score), 0);
    chk("idle_land_pulse", int'(o_score_pulse), 0);

    drive(1, 0, 0, 0);
    chk("start_playing", int'(o_playing), 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0);
      chk("normal_score", int'(o_score), i + 1);
      chk("normal_pulse", int'(o_score_pulse), 1);
      chk("normal_combo", int'(o_combo), 0);
    end
    drive(0, 0, 0, 1);
    chk("r0_high", int'(o_high_score), 3);

    drive(1, 0, 0, 0);
    chk("start_clear_pulse", int'(o_score_pulse), 1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, (i < 3) ? 1'b1 : 1'b0, 0);
      chk("pf_score", int'(o_score), exp_pf[i]);
      chk("pf_combo", int'(o_combo), exp_cb[i]);
    end
    drive(0, 0, 0, 1);
    chk("r1_high", int'(o_high_score), 13);
    chk("r1_rec", int'(o_new_record), 1);

    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 0);
    drive(1, 0, 0, 0);
    chk("start_ignored", int'(o_score), 5);
    drive(0, 1, 1, 1);
    chk("landfall_score", int'(o_score), 5);
    chk("landfall_playing", int'(o_playing), 0);
    chk("landfall_high", int'(o_high_score), 13);
    chk("landfall_rec", int'(o_new_record), 0);

    drive(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) drive(0, 1, 1, 0);
    chk("combo9_score", int'(o_score), 84);
    chk("combo9_combo", int'(o_combo), 7);

    for (int i = 0; i < 902; i++) drive(0, 1, 0, 0);
    chk("preload_score", int'(o_score), 986);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 0);
    chk("near_ceiling", int'(o_score), 998);
    chk("near_combo", int'(o_combo), 3);
    drive(0, 1, 1, 0);
    chk("sat_score", int'(o_score), 999);
    chk("sat_pulse", int'(o_score_pulse), 1);
    drive(0, 1, 0, 0);
    chk("sat_hold", int'(o_score), 999);
    chk("sat_no_pulse", int'(o_score_pulse), 0);
    drive(0, 0, 0, 1);
    chk("max_high", int'(o_high_score), 999);
    chk("max_rec", int'(o_new_record), 1);

    drive(1, 0, 0, 0);
    drive(0, 0, 0, 1);
    chk("zero_round_rec", int'(o_new_record), 0);
    drive(1, 0, 0, 0);
    chk("start_zero_no_pulse", int'(o_score_pulse), 0);
    drive(0, 1, 0, 0);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("midrst_high", int'(o_high_score), 0);
    chk("midrst_score", int'(o_score), 0);
    chk("midrst_playing", int'(o_playing), 0);
    drive(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-side scoring stage for the jump game; sits directly upstream of the 4-digit score display and drives its 10-bit score input.
- Turns landing/fall event pulses from the game FSM into a saturating running score, a perfect-landing combo multiplier and a session high score.
- Registered outputs only; the display stage consumes o_score unchanged.

Parameters:
- MAX_SCORE, 999, saturation ceiling for o_score and o_high_score; must be ≤ 1023.
- NORMAL_PTS, 1, points for a non-perfect landing.
- PERFECT_PTS, 2, base points per combo level for a perfect landing.
- COMBO_MAX, 7, ceiling of the combo counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- i_start  in  1  one-cycle pulse: begin a new round.
- i_land  in  1  one-cycle pulse: player landed on a platform.
- i_perfect  in  1  qualifies i_land; 1 means centre landing; ignored when i_land=0.
- i_fall  in  1  one-cycle pulse: player missed; round ends.
- o_score  out  10  current round score, to the display stage.
- o_high_score  out  10  best score since reset.
- o_combo  out  3  current perfect-landing streak.
- o_playing  out  1  1 while the FSM is in PLAYING.
- o_score_pulse  out  1  one-cycle strobe when o_score changes value.
- o_new_record  out  1  in OVER, 1 if the finished round beat the previous high score.

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst sampled on the rising edge of clk). All state updates on the rising edge of clk.
- Reset: state=IDLE; o_score=0, o_high_score=0, o_combo=0, o_playing=0, o_score_pulse=0, o_new_record=0. rst has priority over every input, including in the middle of a round.
- FSM states: IDLE, PLAYING, OVER.
- IDLE and OVER on i_start=1:
  - Next state is PLAYING.
  - o_score, o_combo and o_new_record clear to 0 on the same edge.
  - o_high_score is kept.
- PLAYING:
  - i_start is ignored.
  - i_fall=1: next state is OVER. o_combo is cleared.
  - At the fall edge, if o_score > o_high_score, then o_high_score <= o_score and o_new_record <= 1. Otherwise o_new_record <= 0.
  - If i_fall and i_land are both 1 in the same cycle, i_fall wins. The landing scores nothing.
- Landing in PLAYING (i_land=1, i_fall=0):
  - Perfect (i_perfect=1): combo_n = min(o_combo+1, COMBO_MAX), add = PERFECT_PTS*combo_n.
  - Not perfect (i_perfect=0): combo_n = 0, add = NORMAL_PTS.
  - o_score <= min(o_score+add, MAX_SCORE). Compute the sum at least 11 bits wide so it cannot wrap before saturation.
  - o_combo <= combo_n.
  - Latency: the new score appears on o_score one cycle after the i_land cycle.
- i_land and i_fall outside PLAYING are ignored.
- o_score_pulse is 1 for exactly the cycle after an edge where o_score changed value:
  - Not asserted for a landing made while already saturated at MAX_SCORE.
  - Asserted when i_start clears a nonzero score.
  - Not asserted for i_start with o_score already 0.
- o_playing = (state==PLAYING), registered.
- o_high_score never decreases except on rst.
- Back-to-back i_land pulses on consecutive cycles are each scored.

Test Plan:
- rst for 2 cycles with random inputs -> all outputs 0, state IDLE; i_land in IDLE -> o_score stays 0.
- i_start, then 3 non-perfect landings -> o_score 1,2,3, each one cycle after its i_land; o_combo 0; three o_score_pulse strobes.
- From score 0: 3 perfect landings, then 1 non-perfect -> o_score 2,6,12,13; o_combo 1,2,3,0.
- 9 consecutive perfect landings -> o_combo saturates at 7. Adds: 2,4,6,8,10,12,14,14,14, giving o_score 84.
- Preload score near the ceiling (repeated landings to 998), then a perfect landing with combo=3 -> o_score=999; another landing -> o_score stays 999 and no o_score_pulse.
- Round 1 ends at 13 -> o_high_score=13, o_new_record=1. Round 2 with simultaneous i_land+i_fall at score 5 -> o_score stays 5, state OVER, o_high_score stays 13, o_new_record=0. rst mid-round -> o_high_score=0.
